sprite_blitter: RTL and testbench

SPRITE_BLITTER -- requirements
Module: sprite_blitter

---
 rtl/sprite_pkg.sv | 17 +
 rtl/sprite_coord_gen.sv | 45 ++++
 rtl/sprite_blitter.sv | 162 ++++++++++++++++
 tb/tb_sprite_blitter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite blitter.
// Optional SPRITE_TRANSPARENCY_EN enables magenta colour-key skipping.
package sprite_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [15:0] TRANSPARENT_KEY = 16'hF81F;
  localparam int LCD_WIDTH_DEF  = 240;
  localparam int LCD_HEIGHT_DEF = 320;

endpackage

// File: rtl/sprite_coord_gen.sv
// Column/row/ROM-address walker for the sprite blitter.
// Raster order, address kept as a running counter.
module sprite_coord_gen
  import sprite_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        advance,
  input  logic [7:0]  width,
  input  logic [8:0]  height,
  output logic [7:0]  col,
  output logic [8:0]  row,
  output logic [15:0] addr,
  output logic        last
);

  logic col_last;
  logic row_last;

  assign col_last = (col == width - 8'd1);
  assign row_last = (row == height - 9'd1);
  assign last     = col_last && row_last;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (clear) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (advance) begin
      addr <= addr + 16'd1;
      if (col_last) begin
        col <= '0;
        row <= row + 9'd1;
      end else begin
        col <= col + 8'd1;
      end
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: ROM fetch, clip, LCD write handshake.
// Define SPRITE_TRANSPARENCY_EN to skip 16'hF81F pixels.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int LCD_WIDTH    = LCD_WIDTH_DEF,
  parameter int LCD_HEIGHT   = LCD_HEIGHT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  spriteId,
  input  logic [7:0]  xOrigin,
  input  logic [8:0]  yOrigin,
  input  logic [7:0]  sprWidth,
  input  logic [8:0]  sprHeight,
  output logic [3:0]  ROMId,
  output logic [15:0] ROMAddr,
  input  logic [15:0] romData,
  output logic [7:0]  xAddr,
  output logic [8:0]  yAddr,
  output logic [15:0] pixelData,
  output logic        pixelWrite,
  input  logic        pixelReady,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] WAIT_LOAD = 8'(READ_LATENCY - 1);
  localparam logic [8:0] X_LIM     = 9'(LCD_WIDTH);
  localparam logic [9:0] Y_LIM     = 10'(LCD_HEIGHT);

  state_t state_q;
  state_t state_d;

  logic [3:0] sid_q;
  logic [7:0] xo_q;
  logic [8:0] yo_q;
  logic [7:0] w_q;
  logic [8:0] h_q;
  logic [7:0] cnt_q;

  logic [7:0] col;
  logic [8:0] row;
  logic       last;
  logic       clear;
  logic       advance;

  logic [8:0] xsum;
  logic [9:0] ysum;
  logic       clipped;
  logic       skip;
  logic       accepted;

  sprite_coord_gen u_coord (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear),
    .advance (advance),
    .width   (w_q),
    .height  (h_q),
    .col     (col),
    .row     (row),
    .addr    (ROMAddr),
    .last    (last)
  );

  assign xsum    = {1'b0, xo_q} + {1'b0, col};
  assign ysum    = {1'b0, yo_q} + {1'b0, row};
  assign clipped = (xsum >= X_LIM) || (ysum >= Y_LIM);

`ifdef SPRITE_TRANSPARENCY_EN
  assign skip = clipped || (romData == TRANSPARENT_KEY);
`else
  assign skip = clipped;
`endif

  assign accepted = (state_q == S_IDLE) && start;

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          clear   = 1'b1;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (cnt_q == 8'd0) begin
          // skipped pixels advance exactly like an accepted write
          if (!skip) begin
            state_d = S_WRITE;
          end else if (last) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            advance = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (pixelReady) begin
          if (last) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            advance = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      sid_q     <= '0;
      xo_q      <= '0;
      yo_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
      cnt_q     <= '0;
      xAddr     <= '0;
      yAddr     <= '0;
      pixelData <= '0;
    end else begin
      state_q <= state_d;
      if (accepted) begin
        sid_q <= spriteId;
        xo_q  <= xOrigin;
        yo_q  <= yOrigin;
        w_q   <= sprWidth;
        h_q   <= sprHeight;
      end
      if (state_q == S_FETCH) begin
        cnt_q <= WAIT_LOAD;
      end else if (state_q == S_WAIT && cnt_q != 8'd0) begin
        cnt_q <= cnt_q - 8'd1;
      end
      if (state_q == S_WAIT && cnt_q == 8'd0) begin
        pixelData <= romData;
        xAddr     <= xsum[7:0];
        yAddr     <= ysum[8:0];
      end
    end
  end

  assign ROMId      = sid_q;
  assign pixelWrite = (state_q == S_WRITE);
  assign busy       = (state_q == S_FETCH) ||
                      (state_q == S_WAIT)  ||
                      (state_q == S_WRITE);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter with a raster-order reference model.
// Honours SPRITE_TRANSPARENCY_EN when compiled with it.
module tb_sprite_blitter;

  localparam int L = 2;

  typedef struct packed {
    logic [7:0]  x;
    logic [8:0]  y;
    logic [15:0] d;
  } wr_t;

  logic        clock;
  logic        reset;
  logic        start;
  logic [3:0]  spriteId;
  logic [7:0]  xOrigin;
  logic [8:0]  yOrigin;
  logic [7:0]  sprWidth;
  logic [8:0]  sprHeight;
  logic [3:0]  ROMId;
  logic [15:0] ROMAddr;
  logic [15:0] romData;
  logic [7:0]  xAddr;
  logic [8:0]  yAddr;
  logic [15:0] pixelData;
  logic        pixelWrite;
  logic        pixelReady;
  logic        busy;
  logic        done;

  sprite_blitter #(.READ_LATENCY(L)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .spriteId   (spriteId),
    .xOrigin    (xOrigin),
    .yOrigin    (yOrigin),
    .sprWidth   (sprWidth),
    .sprHeight  (sprHeight),
    .ROMId      (ROMId),
    .ROMAddr    (ROMAddr),
    .romData    (romData),
    .xAddr      (xAddr),
    .yAddr      (yAddr),
    .pixelData  (pixelData),
    .pixelWrite (pixelWrite),
    .pixelReady (pixelReady),
    .busy       (busy),
    .done       (done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs = 0;
  int stalls = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int t_start = 0;
  int mode = 0;
  int hs_base = 0;
  int stall_left = 0;
  logic [15:0] max_addr = '0;
  logic        stall_prev = 1'b0;
  logic [48:0] held = '0;
  wr_t         exp_q[$];
  logic [15:0] rp[L];

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic logic [15:0] rom_word(input logic [3:0] id,
                                           input logic [15:0] a);
    if (id == 4'd3) return a;
    if (id == 4'd5 && a == 16'd1) return 16'hF81F;
    return (a * 16'd37) ^ {id, 12'h0A5};
  endfunction

  // ROM read stage: fixed-latency pipeline
  always @(posedge clock) begin
    rp[0] <= rom_word(ROMId, ROMAddr);
    for (int i = 1; i < L; i++) rp[i] <= rp[i-1];
  end
  assign romData = rp[L-1];

  // reference: walk the sprite raster, keep on-screen pixels
  task automatic model(input int id, input int xo, input int yo,
                       input int w, input int h, output int lat);
    lat = 1;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        int a, x, y;
        logic [15:0] d;
        bit keep;
        a = r * w + c;
        x = xo + c;
        y = yo + r;
        d = rom_word(4'(id), 16'(a));
        keep = (x < 240) && (y < 320);
`ifdef SPRITE_TRANSPARENCY_EN
        if (d == 16'hF81F) keep = 1'b0;
`endif
        if (keep) begin
          exp_q.push_back('{x: 8'(x), y: 9'(y), d: d});
          lat += L + 2;
        end else begin
          lat += L + 1;
        end
      end
    end
  endtask

  always @(posedge clock) begin
    #1;
    case (mode)
      1: pixelReady = ($urandom_range(0, 2) != 0);
      2: begin
        if (pixelWrite && hs == hs_base + 1 && stall_left > 0) begin
          pixelReady = 1'b0;
          stall_left--;
        end else begin
          pixelReady = 1'b1;
        end
      end
      3: pixelReady = !(pixelWrite && hs == hs_base + 2);
      default: pixelReady = 1'b1;
    endcase
  end

  always @(negedge clock) begin
    if (!reset) begin
      stall_prev = 1'b0;
    end else begin
      if (pixelWrite) begin
        if (stall_prev)
          chk("hold", {xAddr, yAddr, pixelData, ROMAddr}, held);
        if (pixelReady) begin
          stall_prev = 1'b0;
          hs++;
          if (exp_q.size() == 0) begin
            chk("unexpected_write", {xAddr, yAddr, pixelData}, 64'd0);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("write", {xAddr, yAddr, pixelData}, e);
          end
        end else begin
          stall_prev = 1'b1;
          held = {xAddr, yAddr, pixelData, ROMAddr};
          stalls++;
        end
      end else begin
        stall_prev = 1'b0;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_at_done", busy, 0);
      end
      if (ROMAddr > max_addr) max_addr = ROMAddr;
    end
  end

  task automatic start_draw(input int id, input int xo, input int yo,
                            input int w, input int h, output int lat);
    model(id, xo, yo, w, h, lat);
    @(posedge clock);
    #1;
    spriteId  = 4'(id);
    xOrigin   = 8'(xo);
    yOrigin   = 9'(yo);
    sprWidth  = 8'(w);
    sprHeight = 9'(h);
    start     = 1'b1;
    t_start   = cyc;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(negedge clock);
    chk("busy_rise", busy, 1);
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (done_cnt > d0) return;
    end
    chk("done_timeout", done_cnt, d0 + 1);
  endtask

  task automatic run_draw(input int id, input int xo, input int yo,
                          input int w, input int h, input bit lat_chk);
    int lat, d0;
    d0 = done_cnt;
    start_draw(id, xo, yo, w, h, lat);
    wait_done(d0);
    if (lat_chk) chk("latency", done_cyc - t_start, lat);
    repeat (4) @(negedge clock);
    chk("one_done", done_cnt, d0 + 1);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int h0, s0, d0, lat;
    reset = 1'b0;
    start = 1'b0;
    spriteId = '0;
    xOrigin = '0;
    yOrigin = '0;
    sprWidth = '0;
    sprHeight = '0;
    pixelReady = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_outputs",
        {ROMId, ROMAddr, xAddr, yAddr, pixelData, pixelWrite, busy, done},
        64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // basic 2x2 draw, ready tied high
    mode = 0;
    h0 = hs;
    run_draw(3, 10, 20, 2, 2, 1);
    chk("basic_writes", hs - h0, 4);

    // five-cycle stall on the second write
    h0 = hs;
    s0 = stalls;
    hs_base = hs;
    stall_left = 5;
    mode = 2;
    run_draw(3, 10, 20, 2, 2, 0);
    chk("stall_cycles", stalls - s0, 5);
    chk("stall_writes", hs - h0, 4);
    mode = 0;

    // right-edge clipping
    h0 = hs;
    max_addr = '0;
    run_draw(9, 238, 0, 4, 1, 1);
    chk("clip_writes", hs - h0, 2);
    chk("clip_addr", max_addr, 3);

    // colour key at ROM word 1
    h0 = hs;
    run_draw(5, 50, 60, 2, 2, 1);
`ifdef SPRITE_TRANSPARENCY_EN
    chk("key_writes", hs - h0, 3);
`else
    chk("key_writes", hs - h0, 4);
`endif

    // start while busy is ignored
    d0 = done_cnt;
    start_draw(2, 5, 5, 3, 3, lat);
    repeat (4) @(posedge clock);
    #1;
    spriteId = 4'd8;
    xOrigin = 8'd0;
    sprWidth = 8'd10;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done(d0);
    chk("busy_start_latency", done_cyc - t_start, lat);
    repeat (40) @(negedge clock);
    chk("busy_start_done", done_cnt, d0 + 1);
    chk("busy_start_queue", exp_q.size(), 0);

    // reset during the third write
    d0 = done_cnt;
    hs_base = hs;
    mode = 3;
    start_draw(7, 100, 100, 3, 2, lat);
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 300 && !hit; i++) begin
        @(negedge clock);
        if (hs == hs_base + 2 && pixelWrite) hit = 1'b1;
      end
      chk("third_write_seen", hit, 1);
    end
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_outputs",
        {ROMId, ROMAddr, xAddr, yAddr, pixelData, pixelWrite, busy, done},
        64'd0);
    exp_q.delete();
    mode = 0;
    @(negedge clock);
    reset = 1'b1;
    chk("rst_no_done", done_cnt, d0);
    run_draw(7, 100, 100, 3, 2, 1);

    // randomized sprites near the screen edges
    for (int n = 0; n < 12; n++) begin
      int id, xo, yo, w, h;
      bit rnd;
      id = $urandom_range(0, 15);
      xo = $urandom_range(0, 255);
      yo = $urandom_range(0, 340);
      w = $urandom_range(1, 6);
      h = $urandom_range(1, 5);
      rnd = n[0];
      mode = rnd ? 1 : 0;
      run_draw(id, xo, yo, w, h, !rnd);
    end
    mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
